// File: rtl/mod_memaccess.sv
// Data-memory access unit: serves load (line fill) and store (single-word write)
// requests from mod_memstage over the system request/response bus.
module mod_memaccess #(
    parameter int         BEATS     = 8,
    parameter logic [3:0] READ_TAG  = 4'h1,
    parameter logic [3:0] WRITE_TAG = 4'h2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_reqFlag,
    input  logic        store_reqFlag,
    input  logic [63:0] data_reqAddr,
    input  logic [63:0] store_data,
    output logic        reqcyc,
    output logic [63:0] req,
    output logic [3:0]  reqtag,
    input  logic        reqack,
    input  logic        respcyc,
    input  logic [63:0] resp,
    output logic        respack,
    output logic [63:0] load_buffer,
    output logic        load_done,
    output logic        store_opn,
    output logic        busy
);

    localparam int CNT_W    = $clog2(BEATS);
    localparam int LINE_LSB = 3 + CNT_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_RESP,
        ST_ADDR,
        ST_DATA,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             reqcyc_q, reqcyc_d;
    logic [63:0]      req_q, req_d;
    logic [3:0]       reqtag_q, reqtag_d;
    logic [63:3]      addr_q, addr_d;
    logic [63:0]      sdata_q, sdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      lbuf_q, lbuf_d;
    logic             sopn_q, sopn_d;

    // Byte-offset bits never matter: every access is word aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^data_reqAddr[2:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            reqcyc_q <= 1'b0;
            req_q    <= '0;
            reqtag_q <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            cnt_q    <= '0;
            lbuf_q   <= '0;
            sopn_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reqcyc_q <= reqcyc_d;
            req_q    <= req_d;
            reqtag_q <= reqtag_d;
            addr_q   <= addr_d;
            sdata_q  <= sdata_d;
            cnt_q    <= cnt_d;
            lbuf_q   <= lbuf_d;
            sopn_q   <= sopn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        reqcyc_d = reqcyc_q;
        req_d    = req_q;
        reqtag_d = reqtag_q;
        addr_d   = addr_q;
        sdata_d  = sdata_q;
        cnt_d    = cnt_q;
        lbuf_d   = lbuf_q;
        sopn_d   = sopn_q;
        respack  = 1'b0;

        case (state_q)
            IDLE: begin
                // Bus request fields are set up here so they appear registered
                // on the first cycle of the request state.
                if (store_reqFlag) begin
                    addr_d   = data_reqAddr[63:3];
                    sdata_d  = store_data;
                    sopn_d   = 1'b1;
                    reqcyc_d = 1'b1;
                    req_d    = {data_reqAddr[63:3], 3'b000};
                    reqtag_d = WRITE_TAG;
                    state_d  = ST_ADDR;
                end else if (data_reqFlag) begin
                    addr_d   = data_reqAddr[63:3];
                    reqcyc_d = 1'b1;
                    req_d    = {data_reqAddr[63:LINE_LSB], {LINE_LSB{1'b0}}};
                    reqtag_d = READ_TAG;
                    state_d  = LD_REQ;
                end
            end

            LD_REQ: begin
                if (reqack) begin
                    reqcyc_d = 1'b0;
                    req_d    = '0;
                    reqtag_d = '0;
                    cnt_d    = '0;
                    state_d  = LD_RESP;
                end
            end

            LD_RESP: begin
                respack = respcyc;
                if (respcyc) begin
                    if (cnt_q == addr_q[LINE_LSB-1:3]) begin
                        lbuf_d = resp;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ST_ADDR: begin
                if (reqack) begin
                    req_d   = sdata_q;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (reqack) begin
                    reqcyc_d = 1'b0;
                    req_d    = '0;
                    reqtag_d = '0;
                    sopn_d   = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign reqcyc      = reqcyc_q;
    assign req         = req_q;
    assign reqtag      = reqtag_q;
    assign load_buffer = lbuf_q;
    assign load_done   = (state_q == DONE);
    assign store_opn   = sopn_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mod_memaccess.sv
// Scoreboard bench for mod_memaccess: stimulus pushes expected bus requests and
// load words, a negedge monitor pops and compares them as the DUT presents them.
module tb_mod_memaccess;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_reqFlag, store_reqFlag;
    logic [63:0] data_reqAddr, store_data;
    logic        reqcyc;
    logic [63:0] req;
    logic [3:0]  reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic        respack;
    logic [63:0] load_buffer;
    logic        load_done, store_opn, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  t;
    } req_t;

    req_t        exp_req[$];
    logic [63:0] exp_load[$];
    logic [63:0] last_load = '0;
    logic        simple_mem = 1'b0;

    always #5 clk = ~clk;

    mod_memaccess dut (
        .clk          (clk),
        .reset        (reset),
        .data_reqFlag (data_reqFlag),
        .store_reqFlag(store_reqFlag),
        .data_reqAddr (data_reqAddr),
        .store_data   (store_data),
        .reqcyc       (reqcyc),
        .req          (req),
        .reqtag       (reqtag),
        .reqack       (reqack),
        .respcyc      (respcyc),
        .resp         (resp),
        .respack      (respack),
        .load_buffer  (load_buffer),
        .load_done    (load_done),
        .store_opn    (store_opn),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Backing memory: each 64-bit word's content depends only on its address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        w = {a[63:3], 3'b000};
        if (simple_mem) return 64'h100 + {61'b0, a[5:3]};
        return (w * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Monitor
    req_t        m_e;
    logic        held_v = 1'b0;
    logic [63:0] held_req;
    logic [3:0]  held_tag;

    always @(negedge clk) begin
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v && reqcyc) begin
                chk("req_stable", req, held_req);
                chk("reqtag_stable", 64'(reqtag), 64'(held_tag));
            end
            held_v   = reqcyc && !reqack;
            held_req = req;
            held_tag = reqtag;
            if (reqcyc && reqack) begin
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", req, 64'hX);
                end else begin
                    m_e = exp_req.pop_front();
                    chk("req_payload", req, m_e.d);
                    chk("req_tag", 64'(reqtag), 64'(m_e.t));
                end
            end
            if (load_done) begin
                if (exp_load.size() == 0)
                    chk("load_done_unexpected", 64'(load_done), 64'd0);
                else
                    chk("load_buffer", load_buffer, exp_load.pop_front());
            end
            if (respack && !respcyc) chk("respack_without_respcyc", 64'(respack), 64'd0);
        end
    end

    task automatic wait_reqcyc();
        for (int t = 0; t < 20 && !reqcyc; t++) begin
            @(posedge clk); #1;
        end
        chk("reqcyc_seen", 64'(reqcyc), 64'd1);
    endtask

    task automatic ack_req();
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        reqack = 1'b1;
        @(posedge clk); #1;
        reqack = 1'b0;
    endtask

    task automatic check_all_zero();
        chk("rst_reqcyc", 64'(reqcyc), 64'd0);
        chk("rst_req", req, 64'd0);
        chk("rst_reqtag", 64'(reqtag), 64'd0);
        chk("rst_respack", 64'(respack), 64'd0);
        chk("rst_load_buffer", load_buffer, 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_store_opn", 64'(store_opn), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
    endtask

    task automatic do_load(input logic [63:0] a, input int abort_at);
        logic [63:0] line;
        line = {a[63:6], 6'b0};
        exp_req.push_back('{line, 4'h1});
        exp_load.push_back(mem_word(a));
        data_reqFlag = 1'b1;
        data_reqAddr = a;
        wait_reqcyc();
        ack_req();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                respcyc = 1'b0;
                @(posedge clk); #1;
            end
            respcyc = 1'b1;
            resp    = mem_word(line | (64'(i) << 3));
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                check_all_zero();
                void'(exp_load.pop_back());
                last_load    = '0;
                respcyc      = 1'b0;
                data_reqFlag = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk("no_done_after_abort", 64'(load_done), 64'd0);
                reset = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        respcyc = 1'b0;
        for (int t = 0; t < 20 && !load_done; t++) begin
            @(posedge clk); #1;
        end
        chk("load_done_seen", 64'(load_done), 64'd1);
        data_reqFlag = 1'b0;
        last_load    = mem_word(a);
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic also_load);
        exp_req.push_back('{{a[63:3], 3'b000}, 4'h2});
        exp_req.push_back('{d, 4'h2});
        store_reqFlag = 1'b1;
        data_reqAddr  = a;
        store_data    = d;
        if (also_load) data_reqFlag = 1'b1;
        wait_reqcyc();
        store_data = {$urandom, $urandom};
        chk("store_opn_addr_phase", 64'(store_opn), 64'd1);
        ack_req();
        chk("store_opn_data_phase", 64'(store_opn), 64'd1);
        ack_req();
        chk("store_opn_fall", 64'(store_opn), 64'd0);
        store_reqFlag = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        data_reqFlag  = 1'b0;
        store_reqFlag = 1'b0;
        data_reqAddr  = '0;
        store_data    = '0;
        reqack        = 1'b0;
        respcyc       = 1'b0;
        resp          = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        reset = 1'b1;
        @(posedge clk); #1;

        simple_mem = 1'b1;
        do_load(64'h1028, -1);
        simple_mem = 1'b0;

        do_store(64'h2010, 64'hDEAD_BEEF, 1'b0);

        do_store(64'h3058, 64'h1122_3344_5566_7788, 1'b1);
        do_load(64'h3058, -1);

        do_load(64'h4020, 4);
        @(posedge clk); #1;
        do_load(64'h4020, -1);

        respcyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            resp = {$urandom, $urandom};
            #1;
            chk("stray_respack", 64'(respack), 64'd0);
            @(posedge clk); #1;
            chk("stray_load_buffer", load_buffer, last_load);
        end
        respcyc = 1'b0;

        do_load(64'h38, -1);
        do_load(64'h40, -1);

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_store({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
            else
                do_load({$urandom, $urandom}, -1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("exp_req_drained", 64'(exp_req.size()), 64'd0);
        chk("exp_load_drained", 64'(exp_load.size()), 64'd0);
        chk("final_idle", 64'(busy), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
